// File: rtl/keyboard_pkg.sv
// Shared types and widths for the keyboard note path.
// Holds the scheduler state encoding and small elaboration-time helpers.
package keyboard_pkg;

  localparam int NOTE_W  = 4;
  localparam int LAYER_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_key_picker.sv
// Combinational round-robin search: first held key after `pointer`, wrapping,
// with the pointer position itself examined last.
module rr_key_picker
  import keyboard_pkg::*;
#(
  parameter int NUM_KEYS = 8
) (
  input  logic [NUM_KEYS-1:0] keys_s,
  input  logic [NOTE_W-1:0]   pointer,
  output logic                found,
  output logic [NOTE_W-1:0]   index
);

  logic [NOTE_W:0]     w_start;
  logic [NOTE_W:0]     w_sum;
  logic [NUM_KEYS-1:0] w_rot;
  logic [NOTE_W-1:0]   w_off;

  // Rotate so bit 0 is the key just after the pointer.
  assign w_start = {1'b0, pointer} + (NOTE_W+1)'(1);
  assign w_rot   = NUM_KEYS'({keys_s, keys_s} >> w_start);
  assign found   = |w_rot;

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    w_off = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = NOTE_W'(i);
      end else begin
        w_off = w_off;
      end
    end
  end

  assign w_sum = w_start + {1'b0, w_off};
  assign index = (w_sum >= (NOTE_W+1)'(NUM_KEYS)) ?
                 NOTE_W'(w_sum - (NOTE_W+1)'(NUM_KEYS)) : w_sum[NOTE_W-1:0];

endmodule

// File: rtl/note_rr_scheduler.sv
// Round-robin arpeggiator: time-slices the single note player across held keys,
// with a silent gap between different notes and seamless sustain of a lone key.
module note_rr_scheduler
  import keyboard_pkg::*;
#(
  parameter int NUM_KEYS    = 8,
  parameter int SLOT_CYCLES = 5000000,
  parameter int GAP_CYCLES  = 250000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [LAYER_W-1:0]  layer_sel,
  output logic [NOTE_W-1:0]   note,
  output logic [LAYER_W-1:0]  layer,
  output logic                note_valid,
  output logic                slot_start
);

  localparam int CNT_W = $clog2(max2(SLOT_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] SLOT_RELOAD = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [NUM_KEYS-1:0] r_sync1, r_keys_s;
  sched_state_e        r_state, w_state_n;
  logic [NOTE_W-1:0]   r_pointer, w_pointer_n;
  logic [NOTE_W-1:0]   r_note, w_note_n;
  logic [LAYER_W-1:0]  r_layer, w_layer_n;
  logic [CNT_W-1:0]    r_counter, w_counter_n;
  logic                r_note_valid, r_slot_start, w_slot_start_n;
  logic                w_found, w_do_slot, w_cur_held;
  logic [NOTE_W-1:0]   w_index;

  rr_key_picker #(.NUM_KEYS(NUM_KEYS)) u_picker (
    .keys_s  (r_keys_s),
    .pointer (r_pointer),
    .found   (w_found),
    .index   (w_index)
  );

  assign w_cur_held = |(r_keys_s & (NUM_KEYS'(1) << r_pointer));

  // Next-state logic; leaving a slot for a different note goes through GAP
  // unless the gap is configured away, in which case the search runs at once.
  always_comb begin
    w_state_n      = r_state;
    w_pointer_n    = r_pointer;
    w_note_n       = r_note;
    w_layer_n      = r_layer;
    w_counter_n    = r_counter;
    w_slot_start_n = 1'b0;
    w_do_slot      = 1'b0;
    case (r_state)
      IDLE: begin
        w_do_slot = enable && w_found;
      end
      PLAY: begin
        if (!enable) begin
          w_state_n = IDLE;
        end else if (!w_cur_held || (r_counter == '0 && w_index != r_pointer)) begin
          w_state_n   = (GAP_CYCLES == 0) ? IDLE : GAP;
          w_counter_n = GAP_RELOAD;
          w_do_slot   = (GAP_CYCLES == 0) && w_found;
        end else if (r_counter == '0) begin
          w_do_slot = 1'b1;
        end else begin
          w_counter_n = r_counter - CNT_W'(1);
        end
      end
      GAP: begin
        if (!enable) begin
          w_state_n = IDLE;
        end else if (r_counter == '0) begin
          w_state_n = IDLE;
          w_do_slot = w_found;
        end else begin
          w_counter_n = r_counter - CNT_W'(1);
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
    if (w_do_slot) begin
      w_state_n      = PLAY;
      w_pointer_n    = w_index;
      w_note_n       = w_index;
      w_layer_n      = layer_sel;
      w_counter_n    = SLOT_RELOAD;
      w_slot_start_n = 1'b1;
    end else begin
      w_slot_start_n = 1'b0;
    end
  end

  // State, synchronizer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1      <= '0;
      r_keys_s     <= '0;
      r_state      <= IDLE;
      r_pointer    <= NOTE_W'(NUM_KEYS - 1);
      r_counter    <= '0;
      r_note       <= '0;
      r_layer      <= '0;
      r_note_valid <= 1'b0;
      r_slot_start <= 1'b0;
    end else begin
      r_sync1      <= keys;
      r_keys_s     <= r_sync1;
      r_state      <= w_state_n;
      r_pointer    <= w_pointer_n;
      r_counter    <= w_counter_n;
      r_note       <= w_note_n;
      r_layer      <= w_layer_n;
      r_note_valid <= (w_state_n == PLAY);
      r_slot_start <= w_slot_start_n;
    end
  end

  assign note       = r_note;
  assign layer      = r_layer;
  assign note_valid = r_note_valid;
  assign slot_start = r_slot_start;

endmodule

// File: tb/tb_note_rr_scheduler.sv
// Self-checking bench for note_rr_scheduler: hand-derived vector table,
// multi-cycle corner sequences, then random stimulus against a reference model.
module tb_note_rr_scheduler;

  localparam int NK   = 8;
  localparam int SLOT = 8;
  localparam int GAPC = 2;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [7:0] keys;
  logic [2:0] layer_sel;
  logic [3:0] note;
  logic [2:0] layer;
  logic       note_valid, slot_start;

  int n_checks = 0;
  int n_fail   = 0;

  note_rr_scheduler #(.NUM_KEYS(NK), .SLOT_CYCLES(SLOT), .GAP_CYCLES(GAPC)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .keys       (keys),
    .layer_sel  (layer_sel),
    .note       (note),
    .layer      (layer),
    .note_valid (note_valid),
    .slot_start (slot_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] keys;
    logic       en;
    logic [2:0] lsel;
    int         n;
    logic [3:0] note;
    logic [2:0] layer;
    logic       valid;
    logic       start;
  } vec_t;

  vec_t tbl[16];

  // Reference model: slot bookkeeping as "edges left", search via modular scan.
  int         m_phase;  // 0 silent-idle, 1 sounding, 2 articulation gap
  int         m_ptr, m_left;
  logic [7:0] m_sync1, m_ks;
  logic [3:0] m_note;
  logic [2:0] m_layer;
  logic       m_valid, m_start;

  function automatic int find_next(input logic [7:0] ks, input int ptr);
    for (int o = 1; o <= NK; o++) begin
      if (ks[(ptr + o) % NK]) return (ptr + o) % NK;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = NK - 1; m_left = 0;
    m_sync1 = '0; m_ks = '0;
    m_note = '0; m_layer = '0; m_valid = 1'b0; m_start = 1'b0;
  endtask

  task automatic model_step();
    int nxt;
    bit slot;
    slot    = 1'b0;
    nxt     = find_next(m_ks, m_ptr);
    m_start = 1'b0;
    case (m_phase)
      0: if (enable && nxt >= 0) slot = 1'b1;
      1: begin
        if (!enable) m_phase = 0;
        else if (!m_ks[m_ptr]) begin m_phase = 2; m_left = GAPC; end
        else begin
          m_left--;
          if (m_left == 0) begin
            if (nxt == m_ptr) slot = 1'b1;
            else begin m_phase = 2; m_left = GAPC; end
          end
        end
      end
      2: begin
        if (!enable) m_phase = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            if (nxt >= 0) slot = 1'b1;
            else m_phase = 0;
          end
        end
      end
      default: m_phase = 0;
    endcase
    if (slot) begin
      m_phase = 1; m_ptr = nxt; m_note = nxt[3:0];
      m_layer = layer_sel; m_left = SLOT; m_start = 1'b1;
    end
    m_valid = (m_phase == 1);
    m_ks    = m_sync1;
    m_sync1 = keys;
  endtask

  initial begin
    int k, hi;
    // keys, en, lsel, edges, note, layer, valid, start
    tbl[0]  = '{8'h08, 1'b1, 3'd2, 2, 4'd0, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{8'h08, 1'b1, 3'd2, 1, 4'd3, 3'd2, 1'b1, 1'b1};
    tbl[2]  = '{8'h08, 1'b1, 3'd2, 1, 4'd3, 3'd2, 1'b1, 1'b0};
    tbl[3]  = '{8'h08, 1'b1, 3'd2, 7, 4'd3, 3'd2, 1'b1, 1'b1};
    tbl[4]  = '{8'h08, 1'b1, 3'd6, 4, 4'd3, 3'd2, 1'b1, 1'b0};
    tbl[5]  = '{8'h08, 1'b1, 3'd6, 4, 4'd3, 3'd6, 1'b1, 1'b1};
    tbl[6]  = '{8'h22, 1'b1, 3'd1, 3, 4'd3, 3'd6, 1'b0, 1'b0};
    tbl[7]  = '{8'h22, 1'b1, 3'd1, 2, 4'd5, 3'd1, 1'b1, 1'b1};
    tbl[8]  = '{8'h22, 1'b1, 3'd1, 7, 4'd5, 3'd1, 1'b1, 1'b0};
    tbl[9]  = '{8'h22, 1'b1, 3'd1, 1, 4'd5, 3'd1, 1'b0, 1'b0};
    tbl[10] = '{8'h22, 1'b1, 3'd1, 2, 4'd1, 3'd1, 1'b1, 1'b1};
    tbl[11] = '{8'h22, 1'b0, 3'd1, 1, 4'd1, 3'd1, 1'b0, 1'b0};
    tbl[12] = '{8'h22, 1'b1, 3'd3, 1, 4'd5, 3'd3, 1'b1, 1'b1};
    tbl[13] = '{8'h00, 1'b1, 3'd3, 3, 4'd5, 3'd3, 1'b0, 1'b0};
    tbl[14] = '{8'h00, 1'b1, 3'd3, 2, 4'd5, 3'd3, 1'b0, 1'b0};
    tbl[15] = '{8'h00, 1'b1, 3'd3, 3, 4'd5, 3'd3, 1'b0, 1'b0};

    reset = 1'b1; enable = 1'b0; keys = '0; layer_sel = '0;
    #12;
    chk("reset_note",  32'(note), 32'd0);
    chk("reset_layer", 32'(layer), 32'd0);
    chk("reset_valid", 32'(note_valid), 32'd0);
    chk("reset_start", 32'(slot_start), 32'd0);
    reset = 1'b0;

    for (int r = 0; r < 16; r++) begin
      keys = tbl[r].keys; enable = tbl[r].en; layer_sel = tbl[r].lsel;
      repeat (tbl[r].n) @(posedge clk);
      #1;
      chk($sformatf("row%0d_note", r),  32'(note),       32'(tbl[r].note));
      chk($sformatf("row%0d_layer", r), 32'(layer),      32'(tbl[r].layer));
      chk($sformatf("row%0d_valid", r), 32'(note_valid), 32'(tbl[r].valid));
      chk($sformatf("row%0d_start", r), 32'(slot_start), 32'(tbl[r].start));
    end

    // Play key 4, then reset asynchronously between clock edges.
    keys = 8'h10;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_play", 32'({note, note_valid}), 32'({4'd4, 1'b1}));
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_outs", 32'({note, layer, note_valid, slot_start}), 32'd0);
    keys = 8'h81;
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_first", 32'({note, layer, note_valid, slot_start}),
        32'({4'd0, 3'd3, 1'b1, 1'b1}));

    // Drop the playing key mid-slot; the remaining key must then sustain.
    keys = 8'h80;
    k = 0;
    while (note_valid && k < 6) begin @(posedge clk); #1; k++; end
    chk("release_fall_lat", 32'((k >= 2 && k <= 3) ? 1 : 0), 32'd1);
    k = 0;
    while (!note_valid && k < 10) begin @(posedge clk); #1; k++; end
    chk("release_gap_len", 32'(k), 32'd2);
    chk("release_next_note", 32'(note), 32'd7);
    hi = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (note_valid && note == 4'd7) hi++;
    end
    chk("sustain_no_gap", 32'(hi), 32'd20);

    // Random phase against the reference model.
    reset = 1'b1; keys = '0; enable = 1'b1; layer_sel = '0;
    model_reset();
    #2;
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      model_step();
      #1;
      chk("rand_outs", 32'({note, layer, note_valid, slot_start}),
          32'({m_note, m_layer, m_valid, m_start}));
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       keys = '0;
          1:       keys = 8'(1) << $urandom_range(0, 7);
          default: keys = 8'($urandom);
        endcase
      end
      enable = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 7) == 0) layer_sel = 3'($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
